// File: rtl/memwb_stage_param.sv
// MEM/WB pipeline register with flush, x0 suppression, a forwarding tap
// and saturating bubble/hold counters.
module memwb_stage_param #(
    parameter int DATA_W            = 32,
    parameter int ADDR_W            = 5,
    parameter int STALL_W           = 6,
    parameter int STAGE             = 4,
    parameter int CNT_W             = 16,
    parameter int ZERO_REG_SUPPRESS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STALL_W-1:0] stall,
    input  logic              flush,
    input  logic              cnt_clr,
    input  logic              mem_rd_enable,
    input  logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_num,
    output logic              wb_rd_enable,
    output logic [ADDR_W-1:0] wb_rd_addr,
    output logic [DATA_W-1:0] wb_rd_num,
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_num,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  hold_cnt
);

    if (STAGE < 0 || STAGE >= STALL_W) begin : g_bad_stage
        $error("memwb_stage_param: STAGE must be in [0, STALL_W)");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $error("memwb_stage_param: CNT_W must be >= 1");
    end
    if (DATA_W < 1 || ADDR_W < 1) begin : g_bad_width
        $error("memwb_stage_param: DATA_W and ADDR_W must be >= 1");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic s_here;
    logic s_next;
    logic is_bubble;
    logic is_hold;
    logic cap_enable;
    logic stall_unused;

    assign s_here = stall[STAGE];

    // The last stage in the vector has no downstream stall bit.
    if (STAGE + 1 < STALL_W) begin : g_next
        assign s_next = stall[STAGE+1];
    end else begin : g_last
        assign s_next = 1'b0;
    end

    assign stall_unused = ^stall;

    assign is_bubble = s_here && !s_next;
    assign is_hold   = s_here && s_next;

    // A write to x0 has no architectural effect, so drop its enable.
    assign cap_enable = mem_rd_enable &&
                        !((ZERO_REG_SUPPRESS != 0) && (mem_rd_addr == '0));

    // Pipeline register: flush > bubble > hold > advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_rd_enable <= 1'b0;
            wb_rd_addr   <= '0;
            wb_rd_num    <= '0;
        end else if (flush || is_bubble) begin
            wb_rd_enable <= 1'b0;
            wb_rd_addr   <= '0;
            wb_rd_num    <= '0;
        end else if (!is_hold) begin
            wb_rd_enable <= cap_enable;
            wb_rd_addr   <= mem_rd_addr;
            wb_rd_num    <= mem_rd_num;
        end
    end

    // Saturating bubble/hold counters; clear wins, flush suppresses counting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt <= '0;
            hold_cnt   <= '0;
        end else if (cnt_clr) begin
            bubble_cnt <= '0;
            hold_cnt   <= '0;
        end else if (!flush) begin
            if (is_bubble && bubble_cnt != CNT_MAX) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
            if (is_hold && hold_cnt != CNT_MAX) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    assign fwd_valid = wb_rd_enable && (wb_rd_addr != '0);
    assign fwd_addr  = wb_rd_addr;
    assign fwd_num   = wb_rd_num;

endmodule

// File: tb/tb_memwb_stage_param.sv
// Directed bench for memwb_stage_param: default instance plus a
// last-stage instance with 2-bit counters and x0 suppression off.
module tb_memwb_stage_param;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [5:0]  stall = '0;
    logic        flush = 1'b0;
    logic        cnt_clr = 1'b0;
    logic        en = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] num = '0;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_num;
    logic        f_valid;
    logic [4:0]  f_addr;
    logic [31:0] f_num;
    logic [15:0] b_cnt;
    logic [15:0] h_cnt;

    logic [5:0]  a_stall = '0;
    logic        a_flush = 1'b0;
    logic        a_clr = 1'b0;
    logic        a_en = 1'b0;
    logic [4:0]  a_addr = '0;
    logic [31:0] a_num = '0;
    logic        a_wb_en;
    logic [4:0]  a_wb_addr;
    logic [31:0] a_wb_num;
    logic        a_f_valid;
    logic [4:0]  a_f_addr;
    logic [31:0] a_f_num;
    logic [1:0]  a_b_cnt;
    logic [1:0]  a_h_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memwb_stage_param u_dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .cnt_clr(cnt_clr), .mem_rd_enable(en), .mem_rd_addr(addr),
        .mem_rd_num(num), .wb_rd_enable(wb_en), .wb_rd_addr(wb_addr),
        .wb_rd_num(wb_num), .fwd_valid(f_valid), .fwd_addr(f_addr),
        .fwd_num(f_num), .bubble_cnt(b_cnt), .hold_cnt(h_cnt)
    );

    memwb_stage_param #(
        .STAGE(5), .STALL_W(6), .CNT_W(2), .ZERO_REG_SUPPRESS(0)
    ) u_alt (
        .clk(clk), .rst(rst), .stall(a_stall), .flush(a_flush),
        .cnt_clr(a_clr), .mem_rd_enable(a_en), .mem_rd_addr(a_addr),
        .mem_rd_num(a_num), .wb_rd_enable(a_wb_en), .wb_rd_addr(a_wb_addr),
        .wb_rd_num(a_wb_num), .fwd_valid(a_f_valid), .fwd_addr(a_f_addr),
        .fwd_num(a_f_num), .bubble_cnt(a_b_cnt), .hold_cnt(a_h_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_wb(input string tag, input logic e,
                          input logic [4:0] a, input logic [31:0] d);
        chk({tag, ".en"}, 64'(wb_en), 64'(e));
        chk({tag, ".addr"}, 64'(wb_addr), 64'(a));
        chk({tag, ".num"}, 64'(wb_num), 64'(d));
    endtask

    initial begin
        // Reset held across two edges, then released mid-cycle.
        step(2);
        chk_wb("reset", 1'b0, 5'd0, 32'd0);
        chk("reset.bubble", 64'(b_cnt), 64'd0);
        chk("reset.hold", 64'(h_cnt), 64'd0);
        chk("reset.fwd_valid", 64'(f_valid), 64'd0);
        rst = 1'b1;

        // Advance: one-cycle latency to wb_* and fwd_*.
        en = 1'b1; addr = 5'd7; num = 32'hDEADBEEF;
        step(1);
        chk_wb("adv", 1'b1, 5'd7, 32'hDEADBEEF);
        chk("adv.fwd_valid", 64'(f_valid), 64'd1);
        chk("adv.fwd_addr", 64'(f_addr), 64'd7);
        chk("adv.fwd_num", 64'(f_num), 64'hDEADBEEF);

        // Bubble for two cycles after loading 3 / 0x55.
        addr = 5'd3; num = 32'h55;
        step(1);
        chk_wb("load3", 1'b1, 5'd3, 32'h55);
        stall = 6'b010000;
        step(2);
        chk_wb("bubble", 1'b0, 5'd0, 32'd0);
        chk("bubble.cnt", 64'(b_cnt), 64'd2);
        chk("bubble.hold", 64'(h_cnt), 64'd0);

        // Hold for three cycles after loading 9 / 0x1234.
        stall = 6'b000000; addr = 5'd9; num = 32'h1234;
        step(1);
        stall = 6'b110000; addr = 5'd1; num = 32'hAAAA;
        step(3);
        chk_wb("hold", 1'b1, 5'd9, 32'h1234);
        chk("hold.cnt", 64'(h_cnt), 64'd3);
        chk("hold.bubble", 64'(b_cnt), 64'd2);

        // Flush beats the hold; no counter moves.
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        chk_wb("flush_hold", 1'b0, 5'd0, 32'd0);
        chk("flush_hold.hcnt", 64'(h_cnt), 64'd3);
        chk("flush_hold.bcnt", 64'(b_cnt), 64'd2);

        // x0 write is suppressed but addr/data are captured.
        stall = 6'b000000; en = 1'b1; addr = 5'd0; num = 32'hFF;
        step(1);
        chk_wb("x0", 1'b0, 5'd0, 32'hFF);
        chk("x0.fwd_valid", 64'(f_valid), 64'd0);

        // Flush with counter clear: both happen.
        flush = 1'b1; cnt_clr = 1'b1;
        step(1);
        flush = 1'b0;
        chk_wb("flush_clr", 1'b0, 5'd0, 32'd0);
        chk("flush_clr.bcnt", 64'(b_cnt), 64'd0);
        chk("flush_clr.hcnt", 64'(h_cnt), 64'd0);

        // Clear overrides a bubble increment but the bubble still happens.
        addr = 5'd4; num = 32'h44;
        stall = 6'b010000;
        step(1);
        cnt_clr = 1'b0;
        chk("clr_bub.bcnt", 64'(b_cnt), 64'd0);
        chk_wb("clr_bub", 1'b0, 5'd0, 32'd0);

        // Reset during a hold loses the held contents.
        stall = 6'b000000; addr = 5'd12; num = 32'hC0FFEE;
        step(1);
        stall = 6'b110000;
        step(1);
        chk_wb("pre_rst_hold", 1'b1, 5'd12, 32'hC0FFEE);
        chk("pre_rst_hold.hcnt", 64'(h_cnt), 64'd1);
        rst = 1'b0;
        #2;
        chk_wb("async_rst", 1'b0, 5'd0, 32'd0);
        chk("async_rst.hcnt", 64'(h_cnt), 64'd0);
        rst = 1'b1;
        step(1);
        chk_wb("post_rst_hold", 1'b0, 5'd0, 32'd0);
        chk("post_rst_hold.hcnt", 64'(h_cnt), 64'd1);
        stall = 6'b000000; addr = 5'd13; num = 32'h1313;
        step(1);
        chk_wb("post_rst_adv", 1'b1, 5'd13, 32'h1313);

        // Alternate instance: no x0 suppression.
        a_en = 1'b1; a_addr = 5'd0; a_num = 32'hFF;
        step(1);
        chk("alt_x0.en", 64'(a_wb_en), 64'd1);
        chk("alt_x0.num", 64'(a_wb_num), 64'hFF);
        chk("alt_x0.fwd_valid", 64'(a_f_valid), 64'd0);

        // stall[4] alone does not touch a stage-5 register.
        a_addr = 5'd6; a_num = 32'h66; a_stall = 6'b010000;
        step(1);
        chk("alt_s4.addr", 64'(a_wb_addr), 64'd6);
        chk("alt_s4.bcnt", 64'(a_b_cnt), 64'd0);

        // Last stage: stall[5] is a bubble; 2-bit counter saturates at 3.
        a_stall = 6'b100000;
        step(5);
        chk("alt_sat.en", 64'(a_wb_en), 64'd0);
        chk("alt_sat.addr", 64'(a_wb_addr), 64'd0);
        chk("alt_sat.bcnt", 64'(a_b_cnt), 64'd3);
        chk("alt_sat.hcnt", 64'(a_h_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/memwb_stage_param.md
Name: memwb_stage_param

Overview:
- Parametrised pipeline register between the memory-access stage and register write-back.
- Successor of the fixed 32-bit MEM/WB latch.
- Adds configurable data/address width and stall-vector position, a synchronous flush, x0-write suppression, and a write-back forwarding tap.
- Adds saturating bubble/hold performance counters for pipeline tuning.

Parameters:
- DATA_W, 32, width of the write-back data.
- ADDR_W, 5, width of the destination register index.
- STALL_W, 6, width of the global stall vector.
- STAGE, 4, index of this stage's bit in the stall vector; STAGE+1 is the downstream bit.
- CNT_W, 16, width of each performance counter.
- ZERO_REG_SUPPRESS, 1, when 1 a write to register index 0 is dropped.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous reset, active-low
- stall  in  STALL_W  global stall vector from the stall controller
- flush  in  1  synchronous squash of the stage contents
- cnt_clr  in  1  synchronous clear of both counters
- mem_rd_enable  in  1  upstream write-enable
- mem_rd_addr  in  ADDR_W  upstream destination index
- mem_rd_num  in  DATA_W  upstream write data
- wb_rd_enable  out  1  registered write-enable to the register file
- wb_rd_addr  out  ADDR_W  registered destination index
- wb_rd_num  out  DATA_W  registered write data
- fwd_valid  out  1  combinational: wb_rd_enable AND wb_rd_addr != 0
- fwd_addr  out  ADDR_W  equals wb_rd_addr
- fwd_num  out  DATA_W  equals wb_rd_num
- bubble_cnt  out  CNT_W  number of bubbles inserted
- hold_cnt  out  CNT_W  number of cycles the contents were held

Behaviour:
- Reset:
  - rst low forces all registered outputs to 0 immediately, without waiting for clk.
  - This covers wb_rd_enable, wb_rd_addr, wb_rd_num, bubble_cnt and hold_cnt.
  - Reset release is recognised at the next posedge clk.
- Definitions:
  - s_here = stall[STAGE].
  - s_next = stall[STAGE+1] if STAGE+1 < STALL_W, else 0.
- Per-posedge priority, highest first:
  - 1. flush = 1: enable, addr and data all cleared to 0. No counter update.
  - 2. Bubble, s_here = 1 and s_next = 0: enable, addr and data cleared to 0. bubble_cnt increments.
  - 3. Hold, s_here = 1 and s_next = 1: all outputs keep their value. hold_cnt increments.
  - 4. Advance, s_here = 0: capture mem_rd_*. No counter update.
- Advance with x0 suppression:
  - Applies when ZERO_REG_SUPPRESS = 1 and mem_rd_addr == 0.
  - wb_rd_enable is captured as 0; addr and data are still captured.
- Latency: one cycle from an input to wb_*. The fwd_* outputs carry no extra delay beyond that register.
- Counters:
  - Both counters saturate at 2^CNT_W - 1 and never wrap.
  - cnt_clr = 1 zeroes both counters at the posedge.
  - cnt_clr overrides any increment in the same cycle.
  - cnt_clr does not affect the data path.
- Simultaneous events:
  - flush together with a bubble or hold condition: the flush wins, and neither counter moves.
  - flush together with cnt_clr: both actions happen.
- Reset mid-hold: the held contents are lost; the next accepted value comes from an advance.
- Parameter legality:
  - STAGE < STALL_W is required.
  - CNT_W >= 1 is required.
  - DATA_W and ADDR_W >= 1 are required.
  - Violations are flagged at elaboration.

Test Plan:
- Reset then advance:
  - Stimulus: rst low asserted mid-cycle, then release; apply stall = 0, mem_rd_enable = 1, addr = 7, num = 0xDEADBEEF.
  - Response: outputs read 0 while rst is low, with no clock edge needed. One cycle after the input, wb_rd_enable = 1, addr = 7, num = 0xDEADBEEF, and fwd_valid = 1.
- Bubble:
  - Stimulus: after loading addr = 3 / num = 0x55, apply stall = 6'b010000 for 2 cycles.
  - Response: wb_* = 0 and bubble_cnt = 2.
- Hold:
  - Stimulus: after loading addr = 9 / num = 0x1234, apply stall = 6'b110000 for 3 cycles.
  - Response: wb_* stay at 9 / 0x1234, hold_cnt = 3, bubble_cnt unchanged.
- x0 suppression:
  - Stimulus: advance with mem_rd_enable = 1, addr = 0, num = 0xFF.
  - Response: wb_rd_enable = 0, wb_rd_num = 0xFF, fwd_valid = 0.
  - With ZERO_REG_SUPPRESS = 0: wb_rd_enable = 1 and fwd_valid = 0.
- Flush priority:
  - Stimulus: flush = 1 together with stall = 6'b110000 while holding addr = 9.
  - Response: wb_* = 0 and hold_cnt unchanged.
  - Stimulus: flush = 1 together with cnt_clr = 1.
  - Response: both counters = 0.
- Saturation and edge stage:
  - Stimulus: CNT_W = 2 with 5 consecutive bubbles.
  - Response: bubble_cnt = 3.
  - Stimulus: STAGE = 5, STALL_W = 6, stall[5] = 1.
  - Response: behaves as a bubble (s_next = 0).
